// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, applies branch/jump redirects with a counted
// flush, and supports stall and halt/resume. Optional statistics counters: BRANCH_STATS_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        in_clk,
  input  logic        in_rst_n,
  input  logic        in_branch_valid,
  input  logic        in_cidi_control,
  input  logic [31:0] in_branch_target,
  input  logic        in_jump,
  input  logic [31:0] in_jump_target,
  input  logic        in_stall,
  input  logic        in_halt,
  input  logic        in_go,
  output logic [31:0] out_pc,
  output logic        out_flush,
  output logic        out_branch_taken,
  output logic        out_halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] out_branch_count,
  output logic [15:0] out_taken_count
`endif
);

  localparam logic [1:0]  S_RUN      = 2'd0;
  localparam logic [1:0]  S_FLUSH    = 2'd1;
  localparam logic [1:0]  S_HALT     = 2'd2;
  localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES);
  localparam logic [31:0] STEP       = 32'(PC_STEP);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [31:0] r_pc;
  logic        r_taken;

  logic        w_br_taken;
  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc_inc;

  // A taken branch is older than a jump in the same cycle, so its target wins.
  assign w_br_taken = in_branch_valid & ~in_cidi_control;
  assign w_redirect = w_br_taken | in_jump;
  assign w_target   = w_br_taken ? in_branch_target : in_jump_target;
  assign w_pc_inc   = r_pc + STEP;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= 3'd0;
      r_pc    <= RESET_PC;
      r_taken <= 1'b0;
    end else begin
      r_taken <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (in_halt) begin
            r_state <= S_HALT;
          end else if (w_redirect) begin
            r_pc    <= w_target;
            r_state <= S_FLUSH;
            r_cnt   <= FLUSH_INIT;
            r_taken <= 1'b1;
          end else if (!in_stall) begin
            r_pc <= w_pc_inc;
          end
        end
        S_FLUSH: begin
          if (in_halt) begin
            r_state <= S_HALT;
            r_cnt   <= 3'd0;
          end else begin
            if (!in_stall) r_pc <= w_pc_inc;
            // The counter runs even while stalled; the flush window is time-based.
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) r_state <= S_RUN;
          end
        end
        S_HALT: begin
          if (in_go && !in_halt) r_state <= S_RUN;
        end
        default: begin
          r_state <= S_RUN;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  assign out_pc           = r_pc;
  assign out_flush        = (r_state == S_FLUSH);
  assign out_branch_taken = r_taken;
  assign out_halted       = (r_state == S_HALT);

`ifdef BRANCH_STATS_EN
  logic [15:0] r_branch_count;
  logic [15:0] r_taken_count;
  logic        w_count_en;

  // Only requests that the RUN state actually acts on are counted.
  assign w_count_en = (r_state == S_RUN) & ~in_halt;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_branch_count <= 16'd0;
      r_taken_count  <= 16'd0;
    end else if (w_count_en) begin
      if (in_branch_valid && r_branch_count != 16'hFFFF)
        r_branch_count <= r_branch_count + 16'd1;
      if (w_redirect && r_taken_count != 16'hFFFF)
        r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign out_branch_count = r_branch_count;
  assign out_taken_count  = r_taken_count;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model tracks PC, flush window and halt,
// a negedge process compares every cycle, and literal checks pin key points of the test plan.
module tb_pc_sequencer;

  localparam logic [31:0] RPC = 32'h0000_3000;
  localparam int          FC  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bv = 1'b0, cidi = 1'b1, jump = 1'b0, stall = 1'b0, halt = 1'b0, go = 1'b0;
  logic [31:0] btgt = '0, jtgt = '0;
  logic [31:0] pc;
  logic        flush, taken, halted;
`ifdef BRANCH_STATS_EN
  logic [15:0] bcnt, tcnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  pc_sequencer #(.RESET_PC(RPC), .PC_STEP(4), .FLUSH_CYCLES(FC)) dut (
    .in_clk(clk), .in_rst_n(rst_n),
    .in_branch_valid(bv), .in_cidi_control(cidi), .in_branch_target(btgt),
    .in_jump(jump), .in_jump_target(jtgt),
    .in_stall(stall), .in_halt(halt), .in_go(go),
    .out_pc(pc), .out_flush(flush), .out_branch_taken(taken), .out_halted(halted)
`ifdef BRANCH_STATS_EN
    , .out_branch_count(bcnt), .out_taken_count(tcnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: what the outputs must be, from the sequencing rules.
  logic [31:0] m_pc;
  int          m_flush_left;
  bit          m_halted, m_taken;
  int          m_bcnt, m_tcnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = RPC; m_flush_left = 0; m_halted = 0; m_taken = 0; m_bcnt = 0; m_tcnt = 0;
    end else begin
      m_taken = 0;
      if (m_halted) begin
        if (go && !halt) m_halted = 0;
      end else if (m_flush_left > 0) begin
        if (halt) begin
          m_halted = 1; m_flush_left = 0;
        end else begin
          if (!stall) m_pc = m_pc + 32'd4;
          m_flush_left = m_flush_left - 1;
        end
      end else if (halt) begin
        m_halted = 1;
      end else begin
        if (bv) m_bcnt = (m_bcnt < 65535) ? m_bcnt + 1 : m_bcnt;
        if ((bv && !cidi) || jump) begin
          m_tcnt = (m_tcnt < 65535) ? m_tcnt + 1 : m_tcnt;
          m_pc = (bv && !cidi) ? btgt : jtgt;
          m_flush_left = FC;
          m_taken = 1;
        end else if (!stall) begin
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("flush", 32'(flush), 32'(m_flush_left > 0));
      chk("branch_taken", 32'(taken), 32'(m_taken));
      chk("halted", 32'(halted), 32'(m_halted));
`ifdef BRANCH_STATS_EN
      chk("branch_count", 32'(bcnt), 32'(m_bcnt));
      chk("taken_count", 32'(tcnt), 32'(m_tcnt));
`endif
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr();
    bv = 0; cidi = 1; jump = 0; stall = 0; halt = 0; go = 0;
  endtask

  task automatic do_jump(input logic [31:0] t);
    jump = 1; jtgt = t; step(); jump = 0;
  endtask

  initial begin
    step(2);
    chk_en = 1;
    chk("reset pc", pc, 32'h3000);
    chk("reset flags", {29'd0, flush, taken, halted}, 32'd0);
    rst_n = 1;
    chk("post-release pc", pc, 32'h3000);
    step(); chk("seq pc 1", pc, 32'h3004);
    step(); chk("seq pc 2", pc, 32'h3008);

    // Reach PC=0x10 via a jump to 0x8 and its two flush cycles.
    do_jump(32'h8);
    chk("jump pc", pc, 32'h8);
    chk("jump taken pulse", 32'(taken), 32'd1);
    step(); chk("flush pc", pc, 32'hC);
    step(); chk("run after flush", {pc[30:0], flush}, {31'h10, 1'b0});

    // Taken branch to 0x40.
    bv = 1; cidi = 0; btgt = 32'h40; step(); clr();
    chk("branch pc", pc, 32'h40);
    chk("branch flags", {30'd0, taken, flush}, 32'd3);
    step(); chk("branch flush 2", {pc[30:0], flush}, {31'h44, 1'b1});
    step(); chk("branch flush done", {pc[30:0], flush}, {31'h48, 1'b0});

    // Not-taken branch with a jump: jump wins.
    bv = 1; cidi = 1; jump = 1; jtgt = 32'h80; step(); clr();
    chk("nt branch + jump", pc, 32'h80);
    step(2);
    // Taken branch with a jump: branch wins.
    bv = 1; cidi = 0; btgt = 32'h20; jump = 1; jtgt = 32'h80; step(); clr();
    chk("branch beats jump", pc, 32'h20);
    step(2);
    // Not-taken branch alone only increments.
    bv = 1; cidi = 1; btgt = 32'h999; step(); clr();
    chk("nt branch", {pc[30:0], flush}, {31'h2C, 1'b0});

    // Stall holds; redirect under stall still happens; jump inside FLUSH ignored.
    stall = 1; step(); chk("stall hold", pc, 32'h2C);
    jump = 1; jtgt = 32'h100; step();
    chk("redirect under stall", pc, 32'h100);
    jtgt = 32'h200; step();
    chk("stall in flush", pc, 32'h100);
    stall = 0; step(); clr();
    chk("jump in flush ignored", pc, 32'h104);

    // Halt during FLUSH at 0x44, then resume.
    do_jump(32'h40);
    step(); chk("pre-halt pc", pc, 32'h44);
    halt = 1; step();
    chk("halt in flush", {pc[29:0], flush, halted}, {30'h44, 1'b0, 1'b1});
    halt = 0; jump = 1; jtgt = 32'h777; bv = 1; cidi = 0; step(); clr();
    chk("halt ignores redirect", pc, 32'h44);
    halt = 1; go = 1; step(); clr();
    chk("halt+go stays", 32'(halted), 32'd1);
    go = 1; step(); clr();
    chk("go leaves halt", {pc[30:0], halted}, {31'h44, 1'b0});
    step(); chk("resume pc", pc, 32'h48);

    // Halt in RUN beats a simultaneous jump; go outside HALT ignored.
    halt = 1; jump = 1; jtgt = 32'h900; step(); clr();
    chk("halt beats jump", pc, 32'h48);
    go = 1; step(); clr();
    go = 1; step(); clr();
    chk("go in run ignored", pc, 32'h4C);

    // Wrap modulo 2^32.
    do_jump(32'hFFFF_FFF8);
    step(); chk("pc FFFFFFFC", pc, 32'hFFFF_FFFC);
    step(); chk("pc wrap", pc, 32'h0);

    // Reset mid-FLUSH aborts immediately.
    do_jump(32'h500);
    rst_n = 0; #1;
    chk("async reset pc", pc, 32'h3000);
    chk("async reset flush", 32'(flush), 32'd0);
    step(); rst_n = 1; step();

    // Statistics: 3 taken, 2 not-taken branches from a fresh reset.
    for (int i = 0; i < 5; i++) begin
      bv = 1; cidi = (i % 2 == 1); btgt = 32'h600 + 32'(i * 16); step(); clr();
      step(FC);
    end
`ifdef BRANCH_STATS_EN
    chk("branch_count 5", 32'(bcnt), 32'd5);
    chk("taken_count 3", 32'(tcnt), 32'd3);
`endif
    step();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-cycle/pipelined Logisim-derived CPU. It sits directly downstream of the branch-condition evaluator and consumes its `in_cidi_control` verdict, where 1 means fall through and 0 means branch taken. It also accepts unconditional jump requests, stall and halt controls. It holds the architectural PC, performs redirects, and drives a counted flush of wrong-path instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- PC_STEP, 4: sequential increment in bytes.
- FLUSH_CYCLES, 2: number of cycles `out_flush` is held after a redirect. Legal range 1..7.

Ports:
- in_clk, input, 1: clock. All state updates on the rising edge.
- in_rst_n, input, 1: reset, asynchronous, active-low.
- in_branch_valid, input, 1: a conditional branch resolves this cycle.
- in_cidi_control, input, 1: branch verdict. 1 = not taken (continue), 0 = taken.
- in_branch_target, input, 32: target address for a taken branch.
- in_jump, input, 1: unconditional jump request.
- in_jump_target, input, 32: jump destination.
- in_stall, input, 1: hold the PC.
- in_halt, input, 1: halt request.
- in_go, input, 1: resume from halt.
- out_pc, output, 32: current PC (registered).
- out_flush, output, 1: squash younger in-flight instructions.
- out_branch_taken, output, 1: one-cycle pulse, a redirect was accepted.
- out_halted, output, 1: sequencer is in HALT.

## Operation
- States:
  - RUN: normal sequencing.
  - FLUSH: redirect issued, flush counter nonzero.
  - HALT: PC frozen.
- Redirect condition is `redirect = (in_branch_valid & ~in_cidi_control) | in_jump`. It is evaluated only in RUN.
- Redirect target: a taken branch wins over a simultaneous jump, because the branch is the older instruction. Otherwise the target is `in_jump_target`.
- `in_branch_valid` with `in_cidi_control=1` has no effect: PC increments and no flush occurs.
- Per-cycle priority in RUN, highest first:
  1. `in_halt`: go to HALT, PC held.
  2. redirect: PC = target, go to FLUSH, counter = FLUSH_CYCLES.
  3. `in_stall`: PC held.
  4. Otherwise PC = PC + PC_STEP.
- A redirect is honoured even when `in_stall` is high, so a resolved branch is never lost.
- FLUSH:
  - Branch and jump inputs are ignored, since they belong to squashed instructions.
  - PC increments from the target unless stalled.
  - Counter decrements every cycle, stalled or not. Return to RUN when it reaches 0.
  - `in_halt` in FLUSH: go to HALT immediately, flush abandoned, counter cleared.
- HALT:
  - PC is held and all inputs except `in_go` are ignored.
  - `in_go` returns to RUN, and PC resumes incrementing on the following cycle.
  - `in_go` outside HALT is ignored.
  - `in_halt` and `in_go` both high in HALT: stay in HALT.
- Arithmetic: PC + PC_STEP wraps modulo 2^32. Targets are loaded unmodified; no alignment check.

## Timing
- Reset (async assert, sync-style deassert usage) gives: `out_pc` = RESET_PC, state = RUN, `out_flush` = 0, `out_branch_taken` = 0, `out_halted` = 0, counter = 0.
- Reset mid-FLUSH or mid-HALT aborts immediately to the reset values.
- Redirect latency is 1 cycle. If the redirect is sampled at edge N, `out_pc` = target after edge N.
- `out_branch_taken` is high for exactly the cycle after edge N.
- `out_flush` is registered. It is high for FLUSH_CYCLES consecutive cycles starting after edge N.
- A new redirect can be accepted on the first RUN cycle after the flush ends. Back-to-back redirects are therefore spaced by at least FLUSH_CYCLES+1 cycles.
- `out_halted` rises the cycle after `in_halt` is sampled and falls the cycle after `in_go` is sampled.

## Configuration
- BRANCH_STATS_EN
  - Defined: adds outputs `out_branch_count` (16 bits, counts every `in_branch_valid` accepted in RUN) and `out_taken_count` (16 bits, counts taken branches plus jumps).
  - Both counters saturate at 16'hFFFF, reset to 0, and do not count in FLUSH or HALT.
  - Undefined: the ports and logic are absent and all other behaviour is identical.

## Test plan
- Reset with RESET_PC=0x3000, then release with no requests → `out_pc` reads 0x3000, 0x3004, 0x3008 on successive cycles. All flags stay 0.
- At PC=0x10, `in_branch_valid=1`, `in_cidi_control=0`, target 0x40 → next cycle `out_pc`=0x40 and `out_branch_taken`=1. `out_flush`=1 for 2 cycles, then the PC sequence is 0x44, 0x48.
- Branch with `in_cidi_control=1` plus simultaneous `in_jump` to 0x80 → PC=0x80 and a flush occurs. Repeat with the branch taken (target 0x20) → PC=0x20, because the branch wins.
- Redirect asserted while `in_stall=1` → redirect still occurs. A second jump issued during FLUSH is ignored, and PC continues target+4.
- `in_halt` during FLUSH at PC=0x44 → `out_halted`=1, PC stays 0x44 and flush drops. `in_go` → PC resumes at 0x48 one cycle later.
- PC=0xFFFF_FFFC with no requests → next PC is 0x0000_0000. With BRANCH_STATS_EN defined, 3 taken and 2 not-taken branches → `out_branch_count`=5 and `out_taken_count`=3.
